// File: rtl/i3_rr_wr_arbiter.sv
// Three-port round-robin write arbiter feeding one FIFO. A port wins only when its
// head flit matches HEAD; the winner then owns the FIFO for PKT_LEN written flits.
module i3_rr_wr_arbiter #(
   parameter logic [2:0]  HEAD    = 3'b000,
   parameter int unsigned PKT_LEN = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       input_req1,
   input  logic       input_req2,
   input  logic       input_req3,
   input  logic [2:0] head1,
   input  logic [2:0] head2,
   input  logic [2:0] head3,
   input  logic       FIFO_full,
   output logic       input_bussy1,
   output logic       input_bussy2,
   output logic       input_bussy3,
   output logic       FIFO_wr,
   output logic [1:0] select,
   output logic       pkt_done
);

   typedef enum logic {StIdle, StLock} state_t;

   localparam logic [3:0] LAST_CNT = 4'(PKT_LEN - 1);

   state_t     r_state, w_nxt_state;
   logic [1:0] r_grant, w_nxt_grant;   // 0 = none, 1..3 = port
   logic [1:0] r_ptr,   w_nxt_ptr;     // round-robin start port, 1..3
   logic [3:0] r_cnt,   w_nxt_cnt;     // flits written in current packet

   logic [3:1] w_elig;
   logic [3:1] w_busy;
   logic [1:0] w_winner;
   logic       w_req_g;
   logic       w_wr;
   logic       w_done;
   logic [1:0] w_sel;

   // Port eligibility: valid flit carrying the accepted packet-class head code.
   always_comb begin
      w_elig[1] = input_req1 & (head1 == HEAD);
      w_elig[2] = input_req2 & (head2 == HEAD);
      w_elig[3] = input_req3 & (head3 == HEAD);
   end

   // Round-robin search starting at the pointer port; 0 means nobody eligible.
   always_comb begin
      w_winner = 2'd0;
      unique case (r_ptr)
         2'd2: begin
            if      (w_elig[2]) w_winner = 2'd2;
            else if (w_elig[3]) w_winner = 2'd3;
            else if (w_elig[1]) w_winner = 2'd1;
         end
         2'd3: begin
            if      (w_elig[3]) w_winner = 2'd3;
            else if (w_elig[1]) w_winner = 2'd1;
            else if (w_elig[2]) w_winner = 2'd2;
         end
         default: begin
            if      (w_elig[1]) w_winner = 2'd1;
            else if (w_elig[2]) w_winner = 2'd2;
            else if (w_elig[3]) w_winner = 2'd3;
         end
      endcase
   end

   // Request of the currently granted port.
   always_comb begin
      w_req_g = 1'b0;
      unique case (r_grant)
         2'd1:    w_req_g = input_req1;
         2'd2:    w_req_g = input_req2;
         2'd3:    w_req_g = input_req3;
         default: w_req_g = 1'b0;
      endcase
   end

   // Next-state and output decode; only the granted port is ever released from busy.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_grant = r_grant;
      w_nxt_ptr   = r_ptr;
      w_nxt_cnt   = r_cnt;
      w_sel       = 2'd0;
      w_wr        = 1'b0;
      w_busy      = 3'b111;
      w_done      = 1'b0;
      unique case (r_state)
         StIdle: begin
            // Arbitration-cycle flit is refused; the source holds it for next cycle.
            if (w_winner != 2'd0) begin
               w_nxt_state = StLock;
               w_nxt_grant = w_winner;
               w_nxt_cnt   = 4'd0;
            end
         end
         StLock: begin
            w_sel = r_grant;
            w_wr  = w_req_g & ~FIFO_full;
            unique case (r_grant)
               2'd1:    w_busy[1] = FIFO_full;
               2'd2:    w_busy[2] = FIFO_full;
               2'd3:    w_busy[3] = FIFO_full;
               default: w_busy    = 3'b111;
            endcase
            if (w_wr) begin
               if (r_cnt == LAST_CNT) begin
                  w_done      = 1'b1;
                  w_nxt_state = StIdle;
                  w_nxt_ptr   = (r_grant == 2'd3) ? 2'd1 : r_grant + 2'd1;
                  w_nxt_grant = 2'd0;
                  w_nxt_cnt   = 4'd0;
               end else begin
                  w_nxt_cnt = r_cnt + 4'd1;
               end
            end
         end
         default: w_nxt_state = StIdle;
      endcase
   end

   // Output port mapping.
   always_comb begin
      select       = w_sel;
      FIFO_wr      = w_wr;
      pkt_done     = w_done;
      input_bussy1 = w_busy[1];
      input_bussy2 = w_busy[2];
      input_bussy3 = w_busy[3];
   end

   // State registers; reset abandons any packet in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
         r_grant <= 2'd0;
         r_ptr   <= 2'd1;
         r_cnt   <= 4'd0;
      end else begin
         r_state <= w_nxt_state;
         r_grant <= w_nxt_grant;
         r_ptr   <= w_nxt_ptr;
         r_cnt   <= w_nxt_cnt;
      end
   end

endmodule

// File: tb/tb_i3_rr_wr_arbiter.sv
// Directed bench for i3_rr_wr_arbiter: default instance (HEAD=000, PKT_LEN=4) plus a
// HEAD=001, PKT_LEN=1 instance sharing the same inputs.
module tb_i3_rr_wr_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       r1 = 1'b0, r2 = 1'b0, r3 = 1'b0;
   logic [2:0] h1 = 3'b000, h2 = 3'b000, h3 = 3'b000;
   logic       full = 1'b0;

   logic       m_b1, m_b2, m_b3, m_wr, m_done;
   logic [1:0] m_sel;
   logic       q_b1, q_b2, q_b3, q_wr, q_done;
   logic [1:0] q_sel;

   logic [6:0] m_obs, q_obs;
   assign m_obs = {m_sel, m_wr, m_b3, m_b2, m_b1, m_done};
   assign q_obs = {q_sel, q_wr, q_b3, q_b2, q_b1, q_done};

   int n_checks = 0;
   int n_fail   = 0;

   // {select, FIFO_wr, bussy3, bussy2, bussy1, pkt_done}
   localparam logic [6:0] IDLE_V = 7'b00_0_111_0;

   always #5 clk = ~clk;

   i3_rr_wr_arbiter u_dut (
      .clk          (clk),
      .rst          (rst),
      .input_req1   (r1),
      .input_req2   (r2),
      .input_req3   (r3),
      .head1        (h1),
      .head2        (h2),
      .head3        (h3),
      .FIFO_full    (full),
      .input_bussy1 (m_b1),
      .input_bussy2 (m_b2),
      .input_bussy3 (m_b3),
      .FIFO_wr      (m_wr),
      .select       (m_sel),
      .pkt_done     (m_done)
   );

   i3_rr_wr_arbiter #(
      .HEAD    (3'b001),
      .PKT_LEN (1)
   ) u_dut1 (
      .clk          (clk),
      .rst          (rst),
      .input_req1   (r1),
      .input_req2   (r2),
      .input_req3   (r3),
      .head1        (h1),
      .head2        (h2),
      .head3        (h3),
      .FIFO_full    (full),
      .input_bussy1 (q_b1),
      .input_bussy2 (q_b2),
      .input_bussy3 (q_b3),
      .FIFO_wr      (q_wr),
      .select       (q_sel),
      .pkt_done     (q_done)
   );

   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] lk(input logic [1:0] g, input logic w, input logic [2:0] b,
                                     input logic d);
      return {g, w, b, d};
   endfunction

   // Busy pattern {b3,b2,b1} with the granted port free (FIFO not full).
   function automatic logic [2:0] bfree(input int g);
      case (g)
         1:       return 3'b110;
         2:       return 3'b101;
         default: return 3'b011;
      endcase
   endfunction

   int gord[4] = '{1, 2, 3, 1};

   initial begin
      // Reset state
      #1 rst = 1'b1;
      #1 chk("reset_m", m_obs, IDLE_V);
      chk("reset_q", q_obs, IDLE_V);
      tick();
      tick();
      rst = 1'b0;

      // Single port 2 packet
      r2 = 1'b1;
      #1 chk("sp_c0", m_obs, IDLE_V);
      tick();
      for (int k = 1; k <= 4; k++) begin
         #1 chk($sformatf("sp_c%0d", k), m_obs, lk(2'd2, 1'b1, 3'b101, k == 4));
         tick();
      end
      #1 chk("sp_c5", m_obs, IDLE_V);
      r2 = 1'b0;
      tick();

      // Round-robin with all ports eligible from reset
      rst = 1'b1;
      #1 chk("rr_reset", m_obs, IDLE_V);
      tick();
      rst = 1'b0;
      r1 = 1'b1; r2 = 1'b1; r3 = 1'b1;
      for (int p = 0; p < 4; p++) begin
         #1 chk($sformatf("rr_arb%0d", p), m_obs, IDLE_V);
         tick();
         for (int k = 0; k < 4; k++) begin
            #1 chk($sformatf("rr_p%0d_f%0d", p, k), m_obs,
                   lk(2'(gord[p]), 1'b1, bfree(gord[p]), k == 3));
            tick();
         end
      end
      r1 = 1'b0; r2 = 1'b0; r3 = 1'b0;
      #1 chk("rr_end", m_obs, IDLE_V);
      tick();

      // Backpressure on flits 2-3 of a port 1 packet
      r1 = 1'b1;
      #1 chk("bp_arb", m_obs, IDLE_V);
      tick();
      #1 chk("bp_w1", m_obs, lk(2'd1, 1'b1, 3'b110, 1'b0));
      tick();
      full = 1'b1;
      #1 chk("bp_full_a", m_obs, lk(2'd1, 1'b0, 3'b111, 1'b0));
      tick();
      #1 chk("bp_full_b", m_obs, lk(2'd1, 1'b0, 3'b111, 1'b0));
      tick();
      full = 1'b0;
      #1 chk("bp_w2", m_obs, lk(2'd1, 1'b1, 3'b110, 1'b0));
      tick();
      #1 chk("bp_w3", m_obs, lk(2'd1, 1'b1, 3'b110, 1'b0));
      tick();
      #1 chk("bp_w4", m_obs, lk(2'd1, 1'b1, 3'b110, 1'b1));
      tick();
      r1 = 1'b0;
      #1 chk("bp_end", m_obs, IDLE_V);
      tick();

      // Class filter: port1 head 001, port3 head 000
      rst = 1'b1;
      #1 chk("cf_reset", m_obs, IDLE_V);
      tick();
      rst = 1'b0;
      r1 = 1'b1; h1 = 3'b001;
      r3 = 1'b1; h3 = 3'b000;
      #1 chk("cf_arb_m", m_obs, IDLE_V);
      chk("cf_arb_q", q_obs, IDLE_V);
      tick();
      #1 chk("cf_w1_m", m_obs, lk(2'd3, 1'b1, 3'b011, 1'b0));
      chk("p1_w1_q", q_obs, lk(2'd1, 1'b1, 3'b110, 1'b1));
      h3 = 3'b010;
      tick();
      #1 chk("cf_body2", m_obs, lk(2'd3, 1'b1, 3'b011, 1'b0));
      chk("p1_idle_q", q_obs, IDLE_V);
      tick();
      #1 chk("cf_body3", m_obs, lk(2'd3, 1'b1, 3'b011, 1'b0));
      tick();
      #1 chk("cf_body4", m_obs, lk(2'd3, 1'b1, 3'b011, 1'b1));
      tick();
      #1 chk("cf_idle1", m_obs, IDLE_V);
      tick();
      #1 chk("cf_idle2", m_obs, IDLE_V);
      r1 = 1'b0; r3 = 1'b0;
      h1 = 3'b000; h3 = 3'b000;
      tick();

      // Source gap on port 1 while port 2 waits
      r1 = 1'b1; r2 = 1'b1;
      #1 chk("sg_arb", m_obs, IDLE_V);
      tick();
      #1 chk("sg_w1", m_obs, lk(2'd1, 1'b1, 3'b110, 1'b0));
      tick();
      #1 chk("sg_w2", m_obs, lk(2'd1, 1'b1, 3'b110, 1'b0));
      tick();
      r1 = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1 chk($sformatf("sg_gap%0d", k), m_obs, lk(2'd1, 1'b0, 3'b110, 1'b0));
         tick();
      end
      r1 = 1'b1;
      #1 chk("sg_w3", m_obs, lk(2'd1, 1'b1, 3'b110, 1'b0));
      tick();
      #1 chk("sg_w4", m_obs, lk(2'd1, 1'b1, 3'b110, 1'b1));
      tick();
      #1 chk("sg_rearb", m_obs, IDLE_V);
      tick();

      // Reset mid-packet on port 2 after two writes
      #1 chk("rs_w1", m_obs, lk(2'd2, 1'b1, 3'b101, 1'b0));
      tick();
      #1 chk("rs_w2", m_obs, lk(2'd2, 1'b1, 3'b101, 1'b0));
      tick();
      rst = 1'b1;
      #1 chk("rs_async", m_obs, IDLE_V);
      tick();
      #1 chk("rs_hold", m_obs, IDLE_V);
      rst = 1'b0;
      r3 = 1'b1;
      #1 chk("rs_arb", m_obs, IDLE_V);
      tick();
      #1 chk("rs_restart", m_obs, lk(2'd1, 1'b1, 3'b110, 1'b0));

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i3_rr_wr_arbiter.md
I3_RR_WR_ARBITER -- requirements
Module: i3_rr_wr_arbiter

Interface
REQ-001 Parameter HEAD, default 3'b000: packet-class head code; a flit with head field == HEAD starts an eligible packet.
REQ-002 Parameter PKT_LEN, default 4: flits per packet, including the head flit; legal range 1..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 input_req1/2/3  input  1 each  flit valid on input port 1/2/3.
REQ-006 head1/2/3  input  3 each  bits [15:13] of the flit on port 1/2/3.
REQ-007 FIFO_full  input  1  target FIFO cannot accept a write this cycle.
REQ-008 input_bussy1/2/3  output  1 each  1 = flit on that port not accepted this cycle.
REQ-009 FIFO_wr  output  1  write strobe to the target FIFO.
REQ-010 select  output  2  input mux select: 00 none, 01 port1, 10 port2, 11 port3.
REQ-011 pkt_done  output  1  one-cycle pulse when the last flit of a packet is written.

Function
REQ-012 FSM has two states, IDLE and LOCK; state, grant, pointer and counter are registers, and all outputs are combinational from those registers and the current inputs.
REQ-013 Eligible(n) = input_req_n & (head_n == HEAD); it is evaluated only in IDLE.
REQ-014 In IDLE: select = 00, FIFO_wr = 0, all input_bussy = 1, pkt_done = 0.
REQ-015 In IDLE with at least one eligible port: pick the winner round-robin starting at the pointer port (pointer, pointer+1, pointer+2, modulo 3); next state LOCK; grant = winner; count = 0.
REQ-016 In IDLE with no eligible port: remain in IDLE; pointer unchanged.
REQ-017 The first flit is accepted one cycle after the arbitration cycle, because the grant is registered; the arbitration-cycle flit is refused (bussy = 1), so the source holds it.
REQ-018 In LOCK: select = granted port code; FIFO_wr = input_req_g & ~FIFO_full; input_bussy_g = FIFO_full; non-granted input_bussy = 1.
REQ-019 In LOCK the head field is ignored; any flit on the granted port is written, including body flits whose head differs from HEAD.
REQ-020 count increments by 1 on each FIFO_wr; it is 4 bits wide and never wraps within a packet.
REQ-021 A write with count == PKT_LEN-1 causes: pkt_done = 1 in the same cycle; next state IDLE; pointer = granted+1 (port3 wraps to port1); count = 0.
REQ-022 In LOCK, input_req_g = 0 or FIFO_full = 1 means no write: state, count and pointer hold, with no timeout.
REQ-023 FIFO_full and input_req_g both high: FIFO_wr = 0, input_bussy_g = 1, count holds.
REQ-024 PKT_LEN = 1: the first write in LOCK raises pkt_done and returns to IDLE.
REQ-025 A granted port can never win two consecutive packets while another eligible port is waiting in the same arbitration cycle.
REQ-026 Minimum per-packet cost is PKT_LEN+1 cycles: one arbitration cycle plus PKT_LEN write cycles.

Reset
REQ-027 While rst = 1 and immediately after its assertion (asynchronous): state = IDLE; pointer = port1; grant = none; count = 0; select = 00; FIFO_wr = 0; pkt_done = 0; input_bussy1/2/3 = 1.
REQ-028 Reset asserted mid-packet abandons the packet with no further writes; the upstream retransmission policy is outside this block.
REQ-029 The first arbitration takes place on the first rising edge after rst deasserts.

Verification
REQ-030 Single port: HEAD = 000, PKT_LEN = 4, port2 holds req with head 000 and FIFO_full = 0 -> cycle 0 select 00, bussy2 = 1; cycles 1-4 select 10, FIFO_wr = 1, bussy2 = 0; pkt_done in cycle 4; IDLE in cycle 5.
REQ-031 Round-robin: all three ports eligible continuously after reset -> grant order 1, 2, 3, 1, each packet 5 cycles; non-granted bussy always 1.
REQ-032 Backpressure: FIFO_full = 1 for flits 2-3 of a port1 packet -> FIFO_wr = 0 and bussy1 = 1 in those cycles; count holds; pkt_done follows only after 4 actual writes.
REQ-033 Class filter: HEAD = 001, port1 head 000, port3 head 001 -> port3 granted; port1 bussy stays 1; body flits on port3 with head 010 are still written.
REQ-034 Source gap: granted port drops req for 3 cycles mid-packet -> no writes, state stays LOCK, other eligible ports are not granted; the packet resumes and completes.
REQ-035 Reset mid-packet: rst pulsed after 2 writes -> outputs take reset values immediately; next arbitration starts from port1.
